// File: rtl/lshift_iter_if.sv
// lshift_iter_if: start/busy/done handshake bundle for the iterative left shifter.
//   start : request from the controller (sampled only when the unit is ready)
//   a     : operand, captured on the accepting edge
//   b     : shift amount, full width, captured on the accepting edge
//   busy  : high while the unit is stepping through shift stages
//   done  : one-cycle pulse, ans is valid from this cycle
//   ans   : result register, held until the next accepted start
// master = the issuing controller, slave = the shifter.
interface lshift_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] ans;

    modport master (
        output start, a, b,
        input  busy, done, ans
    );

    modport slave (
        input  start, a, b,
        output busy, done, ans
    );
endinterface

// File: rtl/lshift_iter.sv
// lshift_iter: multi-cycle logical left shifter, one log-stage per clock.
// Applies shift stages 2^(LOG2W-1) .. 1 on successive edges, so a WIDTH-bit
// shift costs LOG2W cycles in SHIFT plus one DONE cycle, with a single
// constant-distance mux per stage instead of a full barrel.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset (aborts any in-flight shift)
//   bus  : lshift_iter_if.slave -- start/a/b in, busy/done/ans out
//
// WIDTH must equal 2**LOG2W.
module lshift_iter #(
    parameter int WIDTH = 32,
    parameter int LOG2W = 5
) (
    input  logic         clk,
    input  logic         rst,
    lshift_iter_if.slave bus
);

    localparam int STW = (LOG2W > 1) ? $clog2(LOG2W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] ans_q;
    logic [LOG2W-1:0] amt_q;
    logic             ovf_q;
    logic [STW-1:0]   stage_q;
    logic             accept;
    logic             last_stage;

    // DONE is also a ready state so a controller can issue back-to-back.
    assign accept     = bus.start && ((state_q == IDLE) || (state_q == DONE));
    assign last_stage = (stage_q == STW'(LOG2W - 1));

    // Stage k shifts by 2^(LOG2W-1-k), gated by the matching amount bit.
    // Each candidate is a constant-distance shift, so this is a small mux.
    always_comb begin
        acc_d = acc_q;
        for (int k = 0; k < LOG2W; k++) begin
            if ((stage_q == STW'(k)) && amt_q[LOG2W-1-k]) begin
                acc_d = acc_q << (1 << (LOG2W - 1 - k));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            acc_q   <= '0;
            ans_q   <= '0;
            amt_q   <= '0;
            ovf_q   <= 1'b0;
            stage_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        acc_q   <= bus.a;
                        amt_q   <= bus.b[LOG2W-1:0];
                        // Any amount bit above the stage range means b >= WIDTH,
                        // which shifts everything out.
                        ovf_q   <= |bus.b[WIDTH-1:LOG2W];
                        stage_q <= '0;
                        state_q <= SHIFT;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end

                SHIFT: begin
                    acc_q   <= acc_d;
                    stage_q <= stage_q + STW'(1);
                    if (last_stage) begin
                        // Result goes straight to ans including the last stage,
                        // so DONE does not need an extra copy cycle.
                        ans_q   <= ovf_q ? '0 : acc_d;
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.ans  = ans_q;

endmodule
